// File: rtl/leak_test_sequencer.sv
// leak_test_sequencer
//   Campaign sequencer for the two-copy constant-time multiplier timing-leak
//   tester. Per trial it fills four operand registers from four 32-bit Galois
//   LFSRs, pulses start, then classifies the trial as match / leak / timeout
//   from the tester's timingLeakDone / timingLeak outputs.
//
// Optional feature macro: LEAK_TEST_STOP_ON_LEAK_EN
//   defined   -> the first leaking trial ends the campaign
//   undefined -> all TRIALS trials always run
//
// Ports
//   clk, rst               clock (rising edge), async active-high reset
//   run                    campaign request (honoured in IDLE/DONE only)
//   timingLeakDone         tester: OR of both copies' done
//   timingLeak             tester: NOT of AND of both copies' done
//   start                  one-cycle start pulse to the tester
//   multiplierOne/Two,
//   multiplicandOne/Two    operands, stable from start to end of trial
//   busy                   high except in IDLE and DONE
//   campaignDone           one-cycle pulse on entry to DONE
//   trialCount, leakCount,
//   timeoutCount           saturating 16-bit statistics
//   firstLeakTrial         0-based index of first leak, 16'hFFFF if none
module leak_test_sequencer #(
  parameter int          WIDTH   = 512,
  parameter int          TRIALS  = 16,
  parameter int          TIMEOUT = 4096,
  parameter logic [31:0] SEED    = 32'hACE1_2345
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             timingLeakDone,
  input  logic             timingLeak,
  output logic             start,
  output logic [WIDTH-1:0] multiplierOne,
  output logic [WIDTH-1:0] multiplicandOne,
  output logic [WIDTH-1:0] multiplierTwo,
  output logic [WIDTH-1:0] multiplicandTwo,
  output logic             busy,
  output logic             campaignDone,
  output logic [15:0]      trialCount,
  output logic [15:0]      leakCount,
  output logic [15:0]      timeoutCount,
  output logic [15:0]      firstLeakTrial
);

  localparam int          F    = (WIDTH + 31) / 32;
  localparam int          FW   = (F > 1) ? $clog2(F) : 1;
  localparam int          TW   = $clog2(TIMEOUT + 1);
  localparam logic [31:0] TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_START, S_WAIT, S_GAP, S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [FW-1:0]     r_fill_cnt;
  logic              r_gap_cnt;
  logic [TW-1:0]     r_wait_cnt;
  logic              r_armed;
  logic [31:0]       r_lfsr [4];
  logic [WIDTH-1:0]  r_op   [4];
  logic [WIDTH+31:0] w_cat  [4];

  logic w_fill_last;
  logic w_gap_last;
  logic w_wait_end;
  logic w_eval;
  logic w_tmo;
  logic w_campaign_end;

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
  endfunction

  function automatic logic [31:0] seed_rot(input int k);
    return (k == 0) ? SEED : ((SEED << (8 * k)) | (SEED >> (32 - 8 * k)));
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_fill_last = (r_fill_cnt == FW'(F - 1));
  assign w_gap_last  = r_gap_cnt;
  // Armed is a registered flag, so a done left high from the previous trial
  // cannot be mistaken for this trial's completion.
  assign w_eval      = (r_state == S_WAIT) && r_armed && timingLeakDone;
  assign w_wait_end  = (r_state == S_WAIT) && (r_wait_cnt == TW'(TIMEOUT - 1));
  // Evaluation beats a timeout landing in the same cycle.
  assign w_tmo       = w_wait_end && !w_eval;

`ifdef LEAK_TEST_STOP_ON_LEAK_EN
  assign w_campaign_end = (trialCount == 16'(TRIALS)) || (leakCount != 16'd0);
`else
  assign w_campaign_end = (trialCount == 16'(TRIALS));
`endif

  always_comb begin
    for (int k = 0; k < 4; k++) w_cat[k] = {r_op[k], r_lfsr[k]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    start  = 1'b0;
    busy   = 1'b1;
    case (r_state)
      S_IDLE, S_DONE: begin
        busy = 1'b0;
        if (run) w_next = S_FILL;
      end
      S_FILL:  if (w_fill_last) w_next = S_START;
      S_START: begin
        start  = 1'b1;
        w_next = S_WAIT;
      end
      S_WAIT:  if (w_eval || w_wait_end) w_next = S_GAP;
      S_GAP:   if (w_gap_last) w_next = w_campaign_end ? S_DONE : S_FILL;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        r_lfsr[k] <= seed_rot(k);
        r_op[k]   <= '0;
      end
      r_fill_cnt     <= '0;
      r_gap_cnt      <= 1'b0;
      r_wait_cnt     <= '0;
      r_armed        <= 1'b0;
      campaignDone   <= 1'b0;
      trialCount     <= 16'd0;
      leakCount      <= 16'd0;
      timeoutCount   <= 16'd0;
      firstLeakTrial <= 16'hFFFF;
    end else begin
      campaignDone <= (r_state == S_GAP) && w_gap_last && w_campaign_end;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (run) begin
            r_fill_cnt     <= '0;
            trialCount     <= 16'd0;
            leakCount      <= 16'd0;
            timeoutCount   <= 16'd0;
            firstLeakTrial <= 16'hFFFF;
          end
        end
        S_FILL: begin
          // Shift in 32 fresh bits per operand; bits above WIDTH fall off.
          for (int k = 0; k < 4; k++) begin
            r_op[k]   <= w_cat[k][WIDTH-1:0];
            r_lfsr[k] <= lfsr_next(r_lfsr[k]);
          end
          r_fill_cnt <= w_fill_last ? '0 : r_fill_cnt + FW'(1);
        end
        S_START: begin
          r_wait_cnt <= '0;
          r_armed    <= 1'b0;
        end
        S_WAIT: begin
          r_wait_cnt <= r_wait_cnt + TW'(1);
          if (!timingLeakDone) r_armed <= 1'b1;
          if (w_eval && timingLeak) begin
            leakCount <= sat_inc(leakCount);
            if (firstLeakTrial == 16'hFFFF) firstLeakTrial <= trialCount;
          end
          if (w_tmo) timeoutCount <= sat_inc(timeoutCount);
          if (w_eval || w_wait_end) begin
            trialCount <= sat_inc(trialCount);
            r_gap_cnt  <= 1'b0;
          end
        end
        S_GAP: r_gap_cnt <= ~r_gap_cnt;
        default: ;
      endcase
    end
  end

  assign multiplierOne   = r_op[0];
  assign multiplicandOne = r_op[1];
  assign multiplierTwo   = r_op[2];
  assign multiplicandTwo = r_op[3];

endmodule

// File: tb/tb_leak_test_sequencer.sv
module tb_leak_test_sequencer;
  localparam int          WIDTH   = 64;
  localparam int          TRIALS  = 4;
  localparam int          TIMEOUT = 100;
  localparam int          F       = (WIDTH + 31) / 32;
  localparam logic [31:0] SEED    = 32'hACE1_2345;
  localparam logic [31:0] TAPS    = 32'h8020_0003;
  localparam logic [63:0] OP0_M1  = 64'hACE12345_D65091A1;

  logic clk = 1'b0;
  logic rst, run, tld, tl;
  logic start, busy, campaignDone;
  logic [WIDTH-1:0] m1, c1, m2, c2;
  logic [15:0] trialCount, leakCount, timeoutCount, firstLeakTrial;

  leak_test_sequencer #(.WIDTH(WIDTH), .TRIALS(TRIALS), .TIMEOUT(TIMEOUT), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .run(run), .timingLeakDone(tld), .timingLeak(tl),
    .start(start), .multiplierOne(m1), .multiplicandOne(c1),
    .multiplierTwo(m2), .multiplicandTwo(c2), .busy(busy),
    .campaignDone(campaignDone), .trialCount(trialCount), .leakCount(leakCount),
    .timeoutCount(timeoutCount), .firstLeakTrial(firstLeakTrial)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct { int kind; int delta; } exp_t;  // kind: 0 match, 1 leak, 2 timeout
  exp_t sb[$];

  logic [31:0]      m_lfsr [4];
  logic [WIDTH-1:0] m_op   [4];

  function automatic logic [31:0] step(input logic [31:0] v);
    logic [31:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ TAPS;
    return r;
  endfunction

  task automatic model_reset();
    m_lfsr[0] = SEED;
    m_lfsr[1] = {SEED[23:0], SEED[31:24]};
    m_lfsr[2] = {SEED[15:0], SEED[31:16]};
    m_lfsr[3] = {SEED[7:0],  SEED[31:8]};
    for (int k = 0; k < 4; k++) m_op[k] = '0;
  endtask

  task automatic model_fill();
    for (int i = 0; i < F; i++)
      for (int k = 0; k < 4; k++) begin
        m_op[k]   = (m_op[k] << 32) | WIDTH'(m_lfsr[k]);
        m_lfsr[k] = step(m_lfsr[k]);
      end
  endtask

  task automatic delays(input int scen, input int ti, output int d1, output int d2);
    case (scen)
      0:       begin d1 = 10; d2 = 10; end
      1:       begin d1 = 10; d2 = (ti == 1) ? 11 : 10; end
      default: begin d1 = -1; d2 = -1; end
    endcase
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; tld = 1'b0; tl = 1'b1;
    model_reset();
    #1;
    n_chk++; if (start !== 1'b0) begin n_fail++; $display("FAIL reset_start got %b want 0", start); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_chk++; if (campaignDone !== 1'b0) begin n_fail++; $display("FAIL reset_cdone got %b want 0", campaignDone); end
    n_chk++; if (trialCount !== 16'd0) begin n_fail++; $display("FAIL reset_trial got %h want 0", trialCount); end
    n_chk++; if (leakCount !== 16'd0) begin n_fail++; $display("FAIL reset_leak got %h want 0", leakCount); end
    n_chk++; if (timeoutCount !== 16'd0) begin n_fail++; $display("FAIL reset_tmo got %h want 0", timeoutCount); end
    n_chk++; if (firstLeakTrial !== 16'hFFFF) begin n_fail++; $display("FAIL reset_first got %h want ffff", firstLeakTrial); end
    n_chk++; if (m1 !== '0 || c2 !== '0) begin n_fail++; $display("FAIL reset_ops got %h/%h want 0", m1, c2); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Runs one campaign while acting as the tester; expectations are queued at
  // each start and retired when trialCount advances.
  task automatic run_campaign(input string nm, input int scen, input bit poke_run,
                              input bit chk_const, input int e_trials, input int e_leak,
                              input int e_tmo, input logic [15:0] e_first);
    int cyc = 0, ti = 0, tcnt = -1, first_start = -1, d1 = -1, d2 = -1, dm, pulses = 0;
    logic a = 1'b0, b = 1'b0;
    logic [15:0] p_tc = 0, p_lk = 0, p_to = 0;
    bit fin = 1'b0;
    exp_t e;
    sb.delete();
    run = 1'b1;
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      run = (poke_run && cyc == 20);
      if (start === 1'b1) begin
        if (first_start < 0) first_start = cyc;
        model_fill();
        n_chk++; if (m1 !== m_op[0] || c1 !== m_op[1] || m2 !== m_op[2] || c2 !== m_op[3]) begin
          n_fail++; $display("FAIL %s_ops trial %0d got %h %h %h %h want %h %h %h %h", nm, ti,
                             m1, c1, m2, c2, m_op[0], m_op[1], m_op[2], m_op[3]);
        end
        if (chk_const && ti == 0) begin
          n_chk++; if (m1 !== OP0_M1) begin n_fail++; $display("FAIL %s_m1_const got %h want %h", nm, m1, OP0_M1); end
          n_chk++; if (c1[63:32] !== 32'hE12345AC || m2[63:32] !== 32'h2345ACE1 || c2[63:32] !== 32'h45ACE123) begin
            n_fail++; $display("FAIL %s_seed_rot got %h %h %h want e12345ac 2345ace1 45ace123",
                               nm, c1[63:32], m2[63:32], c2[63:32]);
          end
        end
        delays(scen, ti, d1, d2);
        if (d1 < 0 && d2 < 0) begin e.kind = 2; e.delta = TIMEOUT + 1; end
        else begin
          dm = (d1 < 0) ? d2 : (d2 < 0) ? d1 : (d1 < d2 ? d1 : d2);
          e.kind = (d1 == d2) ? 0 : 1; e.delta = dm + 1;
        end
        sb.push_back(e);
        ti++; tcnt = 0; a = 1'b0; b = 1'b0;
      end else if (tcnt >= 0) tcnt++;
      if (tcnt >= 1) begin
        a = a | (d1 >= 0 && tcnt >= d1);
        b = b | (d2 >= 0 && tcnt >= d2);
      end
      tld = a | b;
      tl  = ~(a & b);
      if (trialCount !== p_tc) begin
        n_chk++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL %s_sb_empty got trial %0d want none", nm, trialCount); end
        else begin
          e = sb.pop_front();
          if (tcnt !== e.delta || leakCount - p_lk !== 16'(e.kind == 1) || timeoutCount - p_to !== 16'(e.kind == 2)) begin
            n_fail++; $display("FAIL %s_trial%0d got cyc %0d dleak %0d dtmo %0d want cyc %0d kind %0d",
                               nm, trialCount, tcnt, leakCount - p_lk, timeoutCount - p_to, e.delta, e.kind);
          end
        end
        p_tc = trialCount; p_lk = leakCount; p_to = timeoutCount;
      end
      if (campaignDone === 1'b1) begin
        pulses++; fin = 1'b1;
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy_at_done got %b want 0", nm, busy); end
      end
    end
    if (!fin) begin n_chk++; n_fail++; $display("FAIL %s_no_done got %0d cycles want campaignDone", nm, cyc); end
    @(negedge clk);
    n_chk++; if (campaignDone !== 1'b0) begin n_fail++; $display("FAIL %s_cdone_width got %b want 0", nm, campaignDone); end
    n_chk++; if (first_start !== F + 1) begin n_fail++; $display("FAIL %s_start_lat got %0d want %0d", nm, first_start, F + 1); end
    n_chk++; if (trialCount !== 16'(e_trials)) begin n_fail++; $display("FAIL %s_trials got %0d want %0d", nm, trialCount, e_trials); end
    n_chk++; if (leakCount !== 16'(e_leak)) begin n_fail++; $display("FAIL %s_leaks got %0d want %0d", nm, leakCount, e_leak); end
    n_chk++; if (timeoutCount !== 16'(e_tmo)) begin n_fail++; $display("FAIL %s_tmos got %0d want %0d", nm, timeoutCount, e_tmo); end
    n_chk++; if (firstLeakTrial !== e_first) begin n_fail++; $display("FAIL %s_first got %h want %h", nm, firstLeakTrial, e_first); end
    n_chk++; if (sb.size() != 0) begin n_fail++; $display("FAIL %s_sb_left got %0d want 0", nm, sb.size()); end
    tld = 1'b0; tl = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_all_match();
    run_campaign("match", 0, 1'b1, 1'b1, TRIALS, 0, 0, 16'hFFFF);
  endtask

  task automatic test_one_leak();
`ifdef LEAK_TEST_STOP_ON_LEAK_EN
    run_campaign("leak", 1, 1'b0, 1'b0, 2, 1, 0, 16'd1);
`else
    run_campaign("leak", 1, 1'b0, 1'b0, TRIALS, 1, 0, 16'd1);
`endif
  endtask

  task automatic test_timeouts();
    run_campaign("tmo", 2, 1'b0, 1'b0, TRIALS, 0, TRIALS, 16'hFFFF);
  endtask

  task automatic test_mid_reset();
    int starts = 0, k = -1;
    bit hit = 1'b0, got = 1'b0;
    tld = 1'b0; tl = 1'b1;
    run = 1'b1;
    for (int c = 0; c < 2000 && !hit; c++) begin
      @(negedge clk);
      run = 1'b0;
      if (start === 1'b1) begin starts++; if (starts == 3) k = 0; end
      else if (k >= 0) k++;
      if (k == 5) hit = 1'b1;
    end
    n_chk++; if (!hit) begin n_fail++; $display("FAIL midrst_reach got starts %0d want 3", starts); end
    rst = 1'b1;
    #1;
    n_chk++; if (busy !== 1'b0 || trialCount !== 16'd0 || timeoutCount !== 16'd0 || firstLeakTrial !== 16'hFFFF || m1 !== '0) begin
      n_fail++; $display("FAIL midrst_vals got busy %b trial %0d tmo %0d first %h m1 %h want 0 0 0 ffff 0",
                         busy, trialCount, timeoutCount, firstLeakTrial, m1);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    run = 1'b1;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      run = 1'b0;
      if (start === 1'b1) got = 1'b1;
    end
    n_chk++; if (!got) begin n_fail++; $display("FAIL midrst_restart got no start want start"); end
    model_fill();
    n_chk++; if (m1 !== OP0_M1 || m2 !== m_op[2]) begin
      n_fail++; $display("FAIL midrst_ops got %h %h want %h %h", m1, m2, OP0_M1, m_op[2]);
    end
    rst = 1'b1;
    #1;
    n_chk++; if (start !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL async_start got start %b busy %b want 0 0", start, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_all_match();
    test_one_leak();
    test_timeouts();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
